multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the single-issue RV32I-subset datapath through five phases: IF, ID, EX, MEM and WB.
- Decodes the fetched instruction into datapath controls: ALUSrc, ALUCtrl, MemToReg, RegWrite, PCSrc and loadPC.
- Drives the data-memory request handshake, with a timeout.
- Sits beside the datapath in the CPU top level and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for dAck before aborting the access (minimum 1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction word, stable from IF through WB.
- Zero  in  1  ALU zero flag from the datapath.
- dAck  in  1  data memory acknowledge; one-cycle pulse.
- ALUSrc  out  1  1 = immediate is ALU operand 2.
- ALUCtrl  out  4  ALU operation code.
- MemToReg  out  1  1 = write-back value from dReadData.
- RegWrite  out  1  register file write enable.
- PCSrc  out  1  1 = take branch offset.
- loadPC  out  1  PC update strobe.
- MemRead  out  1  load request, level.
- MemWrite  out  1  store request, level.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- memTimeout  out  1  one-cycle pulse on an aborted memory access.
- state  out  3  current FSM state, for debug.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: when rst=0, asynchronously set state=IF, instret=0, wait counter=0. All strobes (RegWrite, loadPC, MemRead, MemWrite, illegal, memTimeout, PCSrc) are 0 during reset.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. No other codes are reachable; any other code returns to IF on the next cycle.
- Transitions:
  - IF->ID->EX unconditionally.
  - EX->MEM for LW/SW; EX->WB for all other instructions.
  - MEM->WB on dAck=1, or when the wait counter reaches MEM_TIMEOUT-1 without dAck.
  - WB->IF.
  - A base instruction takes 4 cycles; LW/SW take at least 5.
- Decode: combinational from instr plus state. Opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BEQ=1100011.
- ALUSrc: 1 for I, LW and SW; otherwise 0.
- ALUCtrl:
  - LW, SW: ADD.
  - BEQ: SUB.
  - R-type and I-type: from funct3 and funct7[5]. SUB and SRA need funct7[5]=1. For I-type, funct7[5] is honoured only for SRAI.
- Phase-gated outputs (all 0 outside the named state):
  - MemRead: 1 in MEM for LW, held until dAck or timeout.
  - MemWrite: 1 in MEM for SW, held until dAck or timeout.
  - RegWrite: 1 in WB for R, I and LW only.
  - MemToReg: 1 in WB for LW.
  - loadPC: 1 in WB for exactly one cycle per instruction.
  - PCSrc: 1 in WB only when the instruction is BEQ and Zero=1.
- Illegal instruction:
  - Asserts illegal for one cycle in ID.
  - EX and WB still run, with RegWrite, MemRead, MemWrite and PCSrc forced to 0.
  - loadPC=1, so PC advances by 4.
- Timeout:
  - The wait counter clears on entering MEM and increments each MEM cycle without dAck.
  - On expiry, memTimeout pulses for one cycle in the MEM exit cycle.
  - The following WB suppresses RegWrite for LW; loadPC still asserts.
  - A dAck arriving in the same cycle as expiry wins: it counts as a normal completion and memTimeout stays 0.
- dAck outside MEM is ignored.
- instret: increments by 1 in every WB cycle, wrapping modulo 2^CNT_W. Illegal and timed-out instructions count.
- Reset mid-operation: rst=0 in any state (including MEM with MemWrite high) drops all strobes immediately and returns to IF; no partial write completes from the controller side.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants R_TYPE, I_TYPE, LW, SW, B_TYPE;
  - funct3 constants;
  - ALU codes AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101;
  - state encodings.
- One sub-module, alu_decoder: purely combinational, maps opcode/funct3/funct7[5] to ALUCtrl and a legal flag.
- The FSM, counters and phase gating stay in multicycle_ctrl.

Test Plan:
- Reset: rst=0 mid-MEM with MemWrite=1 -> same cycle MemWrite=0 and state=0. After release: state 0,1,2,4 for ADD 0x00208033; instret=1 after WB.
- R/I decode:
  - SUB 0x40208033 -> ALUCtrl=0110, ALUSrc=0, RegWrite=1 only in WB.
  - SRAI 0x4020D093 -> ALUCtrl=1010, ALUSrc=1.
- Load/store handshake: LW 0x0000A083 with dAck after 3 MEM cycles -> MemRead high exactly 3 cycles, then WB with MemToReg=1, RegWrite=1.
- Store: SW 0x0020A023 -> MemWrite in MEM only; RegWrite never 1.
- Branch: BEQ 0x00208463 with Zero=1 -> PCSrc=1 and loadPC=1 in WB. With Zero=0 -> PCSrc=0, loadPC=1.
- Timeout and illegal:
  - LW with no dAck, MEM_TIMEOUT=16 -> 16 MEM cycles, memTimeout pulse, RegWrite=0 in WB.
  - Opcode 0x7F -> illegal pulse in ID, no RegWrite, loadPC=1.
  - dAck on the expiry cycle -> memTimeout=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control path: opcodes, funct3 values,
// ALU operation codes and FSM state encoding.
package ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [OPC_W-1:0] R_TYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] I_TYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] LW     = 7'b0000011;
  localparam logic [OPC_W-1:0] SW     = 7'b0100011;
  localparam logic [OPC_W-1:0] B_TYPE = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [F3_W-1:0] F3_SR      = 3'b101;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;
  localparam logic [F3_W-1:0] F3_WORD    = 3'b010;
  localparam logic [F3_W-1:0] F3_BEQ     = 3'b000;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;

  typedef enum logic [STATE_W-1:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == LW) || (opc == SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decode: ALU operation code plus a legality flag
// for the supported RV32I subset.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  logic is_r;

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    is_r     = (opcode == R_TYPE);
    case (opcode)
      LW, SW: begin
        alu_ctrl = ALU_ADD;
        legal    = (funct3 == F3_WORD);
      end
      B_TYPE: begin
        alu_ctrl = ALU_SUB;
        legal    = (funct3 == F3_BEQ);
      end
      R_TYPE, I_TYPE: begin
        // funct7[5] selects SUB/SRA; for I-type it is immediate data except on shifts right.
        legal = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_ctrl = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
          F3_SLL: begin
            alu_ctrl = ALU_SLL;
            legal    = !(is_r && funct7_b5);
          end
          F3_SLT: begin
            alu_ctrl = ALU_SLT;
            legal    = !(is_r && funct7_b5);
          end
          F3_XOR: begin
            alu_ctrl = ALU_XOR;
            legal    = !(is_r && funct7_b5);
          end
          F3_SR:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          F3_OR: begin
            alu_ctrl = ALU_OR;
            legal    = !(is_r && funct7_b5);
          end
          F3_AND: begin
            alu_ctrl = ALU_AND;
            legal    = !(is_r && funct7_b5);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-phase (IF/ID/EX/MEM/WB) control FSM for a multicycle RV32I-subset
// datapath, with data-memory handshake timeout and retired-instruction count.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             Zero,
  input  logic             dAck,
  output logic             ALUSrc,
  output logic [3:0]       ALUCtrl,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic             loadPC,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             illegal,
  output logic             memTimeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       legal;
  logic       is_lw, is_sw, is_beq, writes_rd;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (instr[30]),
    .alu_ctrl  (ALUCtrl),
    .legal     (legal)
  );

  // Illegal instructions never reach MEM and never write state.
  assign is_lw     = legal && (opcode == LW);
  assign is_sw     = legal && (opcode == SW);
  assign is_beq    = legal && (opcode == B_TYPE);
  assign writes_rd = legal && ((opcode == R_TYPE) || (opcode == I_TYPE));

  assign ALUSrc  = (opcode == I_TYPE) || is_mem_op(opcode);
  assign state   = state_q;
  assign instret = instret_q;

  // Next-state and phase-gated decode outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tmo_d      = tmo_q;
    instret_d  = instret_q;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    loadPC     = 1'b0;
    PCSrc      = 1'b0;
    illegal    = 1'b0;
    memTimeout = 1'b0;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        illegal = !legal;
        state_d = ST_EX;
      end
      ST_EX: begin
        tmo_d = 1'b0;
        if (is_lw || is_sw) begin
          wait_d  = '0;
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        // An acknowledge on the expiry cycle is a normal completion.
        if (dAck) begin
          state_d = ST_WB;
        end else if (wait_q == WAIT_LAST) begin
          memTimeout = 1'b1;
          tmo_d      = 1'b1;
          state_d    = ST_WB;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      ST_WB: begin
        loadPC    = 1'b1;
        RegWrite  = writes_rd || (is_lw && !tmo_q);
        MemToReg  = is_lw;
        PCSrc     = is_beq && Zero;
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IF;
      wait_q    <= '0;
      tmo_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
    end
  end

endmodule
